// File: rtl/td4_run_ctrl.sv
// TD4 execution sequencer: issues the registered single-cycle cpu_ce and implements
// halt/run/single-step control, a PC breakpoint and auto-halt on a JMP-to-self idle loop.
module td4_run_ctrl #(
  parameter logic [23:0] DIV_SLOW = 24'd10_000_000,
  parameter logic [23:0] DIV_MED  = 24'd1_000_000,
  parameter logic [23:0] DIV_FAST = 24'd100_000,
  parameter int unsigned CYC_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic [1:0]       speed_sel,
  input  logic             bp_en,
  input  logic [3:0]       bp_addr,
  input  logic [3:0]       pc,
  input  logic [7:0]       memdata,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [1:0]       halt_cause,
  output logic [CYC_W-1:0] icount
);

  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;
  localparam logic [1:0] ST_BRK  = 2'b11;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_BP   = 2'b01;
  localparam logic [1:0] CAUSE_LOOP = 2'b10;

  logic        run_prev, halt_prev, step_prev;
  logic [1:0]  speed_prev;
  logic [23:0] presc, presc_n, div_last;
  logic        bp_skip, skip_n;
  logic [1:0]  state_n, cause_n;
  logic        ce_n;
  logic        run_edge, halt_edge, step_edge;
  logic        speed_chg, tick, bp_hit, selfloop;

  assign run_edge  = run_req  & ~run_prev;
  assign halt_edge = halt_req & ~halt_prev;
  assign step_edge = step_req & ~step_prev;
  assign speed_chg = (speed_sel != speed_prev);

  assign bp_hit   = bp_en & (pc == bp_addr) & ~bp_skip;
  assign selfloop = (memdata[7:4] == 4'b1111) & (memdata[3:0] == pc);

  always_comb begin
    case (speed_sel)
      2'b00:   div_last = DIV_SLOW - 24'd1;
      2'b01:   div_last = DIV_MED - 24'd1;
      default: div_last = DIV_FAST - 24'd1;
    endcase
  end

  // A speed change restarts the count and swallows any tick due in that cycle.
  assign tick = (state == ST_RUN) & ~speed_chg &
                ((speed_sel == 2'b11) | (presc == div_last));

  always_comb begin
    state_n = state;
    cause_n = halt_cause;
    ce_n    = 1'b0;
    skip_n  = bp_skip;
    presc_n = presc;
    if (state == ST_RUN) begin
      presc_n = (speed_chg || tick) ? '0 : presc + 24'd1;
    end
    case (state)
      ST_HALT: begin
        if (!halt_edge) begin
          if (step_edge) begin
            state_n = ST_STEP;
          end else if (run_edge) begin
            state_n = ST_RUN;
            cause_n = CAUSE_NONE;
            presc_n = '0;
          end
        end
      end
      ST_RUN: begin
        if (halt_edge) begin
          state_n = ST_HALT;
          cause_n = CAUSE_NONE;
        end else if (tick) begin
          if (bp_hit) begin
            state_n = ST_BRK;
            cause_n = CAUSE_BP;
          end else begin
            ce_n   = 1'b1;
            skip_n = 1'b0;
            if (selfloop) begin
              state_n = ST_HALT;
              cause_n = CAUSE_LOOP;
            end
          end
        end
      end
      ST_STEP: begin
        state_n = ST_HALT;
        if (!halt_edge) begin
          ce_n    = 1'b1;
          cause_n = selfloop ? CAUSE_LOOP : CAUSE_NONE;
        end
      end
      ST_BRK: begin
        if (halt_edge) begin
          state_n = ST_HALT;
        end else if (step_edge) begin
          state_n = ST_STEP;
        end else if (run_edge) begin
          state_n = ST_RUN;
          skip_n  = 1'b1;
          presc_n = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_HALT;
      halt_cause <= CAUSE_NONE;
      cpu_ce     <= 1'b0;
      icount     <= '0;
      presc      <= '0;
      bp_skip    <= 1'b0;
      run_prev   <= 1'b0;
      halt_prev  <= 1'b0;
      step_prev  <= 1'b0;
      speed_prev <= '0;
    end else begin
      state      <= state_n;
      halt_cause <= cause_n;
      cpu_ce     <= ce_n;
      presc      <= presc_n;
      bp_skip    <= skip_n;
      run_prev   <= run_req;
      halt_prev  <= halt_req;
      step_prev  <= step_req;
      speed_prev <= speed_sel;
      if (ce_n && (icount != '1)) begin
        icount <= icount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Bench for td4_run_ctrl: directed scenarios plus random requests, checked every cycle
// against a cycle-level reference model; the bench also plays the TD4 core (pc/ROM).
module tb_td4_run_ctrl;

  localparam logic [23:0] P_SLOW = 24'd9;
  localparam logic [23:0] P_MED  = 24'd6;
  localparam logic [23:0] P_FAST = 24'd4;
  localparam int unsigned P_W    = 6;
  localparam int IC_MAX = (1 << P_W) - 1;

  localparam int S_HALT = 0, S_RUN = 1, S_STEP = 2, S_BRK = 3;
  localparam int C_NONE = 0, C_BP = 1, C_LOOP = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           run_req, halt_req, step_req;
  logic [1:0]     speed_sel;
  logic           bp_en;
  logic [3:0]     bp_addr;
  logic [3:0]     pc;
  logic [7:0]     memdata;
  logic           cpu_ce;
  logic [1:0]     state;
  logic [1:0]     halt_cause;
  logic [P_W-1:0] icount;

  always #5 clk = ~clk;

  td4_run_ctrl #(
    .DIV_SLOW(P_SLOW),
    .DIV_MED (P_MED),
    .DIV_FAST(P_FAST),
    .CYC_W   (P_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run_req   (run_req),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .speed_sel (speed_sel),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .memdata   (memdata),
    .cpu_ce    (cpu_ce),
    .state     (state),
    .halt_cause(halt_cause),
    .icount    (icount)
  );

  int total = 0;
  int bad = 0;
  int ce_seen = 0;
  int base;
  int ic_before;
  logic [7:0] rom [16];

  int m_state, m_cause, m_icount, m_cnt, p_speed;
  bit m_ce, m_skip, p_run, p_halt, p_step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] s);
    case (s)
      2'b00:   return int'(P_SLOW);
      2'b01:   return int'(P_MED);
      default: return int'(P_FAST);
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_HALT; m_cause = C_NONE; m_icount = 0; m_cnt = 0;
    m_ce = 0; m_skip = 0; p_run = 0; p_halt = 0; p_step = 0; p_speed = 0;
  endtask

  task automatic set_pc(input logic [3:0] v);
    pc = v;
    memdata = rom[pc];
  endtask

  task automatic fill_rom_plain();
    for (int i = 0; i < 16; i++) rom[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
    memdata = rom[pc];
  endtask

  // One clock: predict from current inputs, let the edge pass, play the core, compare.
  task automatic cycle();
    bit re, he, se, bph, lp, tk, nce, nskip;
    int ns, nc, ncnt, nic, dv;
    re = run_req & ~p_run;
    he = halt_req & ~p_halt;
    se = step_req & ~p_step;
    ns = m_state; nc = m_cause; ncnt = m_cnt; nic = m_icount;
    nce = 0; nskip = m_skip; tk = 0;
    bph = bp_en && (pc == bp_addr) && !m_skip;
    lp  = (memdata == {4'hF, pc});
    dv  = div_of(speed_sel);
    case (m_state)
      S_HALT: if (!he) begin
        if (se) ns = S_STEP;
        else if (re) begin ns = S_RUN; nc = C_NONE; ncnt = 0; end
      end
      S_RUN: begin
        if (he) begin ns = S_HALT; nc = C_NONE; end
        else if (int'(speed_sel) != p_speed) ncnt = 0;
        else begin
          tk = (speed_sel == 2'b11) || (m_cnt % dv == dv - 1);
          ncnt = m_cnt + 1;
          if (tk) begin
            if (bph) begin ns = S_BRK; nc = C_BP; end
            else begin
              nce = 1; nskip = 0;
              if (lp) begin ns = S_HALT; nc = C_LOOP; end
            end
          end
        end
      end
      S_STEP: begin
        ns = S_HALT;
        if (!he) begin nce = 1; nc = lp ? C_LOOP : C_NONE; end
      end
      default: begin
        if (he) ns = S_HALT;
        else if (se) ns = S_STEP;
        else if (re) begin ns = S_RUN; nskip = 1; ncnt = 0; end
      end
    endcase
    if (nce && nic < IC_MAX) nic++;
    @(posedge clk);
    #1;
    if (m_ce) pc = (rom[pc][7:4] == 4'hF) ? rom[pc][3:0] : pc + 4'd1;
    memdata = rom[pc];
    m_state = ns; m_cause = nc; m_cnt = ncnt; m_icount = nic; m_ce = nce; m_skip = nskip;
    p_run = run_req; p_halt = halt_req; p_step = step_req; p_speed = int'(speed_sel);
    if (cpu_ce === 1'b1) ce_seen++;
    chk("m_state", state, m_state);
    chk("m_cause", halt_cause, m_cause);
    chk("m_ce", cpu_ce, m_ce);
    chk("m_icount", icount, m_icount);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_req = 0; halt_req = 0; step_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_ce", cpu_ce, 0);
    chk("rst_cause", halt_cause, 0);
    chk("rst_icount", icount, 0);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run_req = 0; halt_req = 0; step_req = 0;
    speed_sel = 2'b00; bp_en = 0; bp_addr = 4'd0; pc = 4'd0;
    fill_rom_plain();
    model_reset();
    do_reset();

    // idle after reset
    base = ce_seen;
    repeat (100) cycle();
    chk("idle_ce", ce_seen - base, 0);
    chk("idle_state", state, 0);
    chk("idle_icount", icount, 0);

    // full speed, held run level must not retrigger
    speed_sel = 2'b11;
    run_req = 1;
    cycle();
    base = ce_seen;
    repeat (5) cycle();
    chk("fast_pulses", ce_seen - base, 5);
    chk("fast_icount", icount, 5);
    run_req = 0; halt_req = 1;
    cycle();
    chk("halt_next", state, 0);
    halt_req = 0;
    cycle();

    // divided rate, then restart on speed change
    speed_sel = 2'b10;
    run_req = 1; cycle(); run_req = 0;
    base = ce_seen;
    repeat (16) cycle();
    chk("div4_pulses", ce_seen - base, 4);
    speed_sel = 2'b01;
    base = ce_seen;
    repeat (6) cycle();
    chk("restart_quiet", ce_seen - base, 0);
    cycle();
    chk("restart_ce", cpu_ce, 1);
    halt_req = 1; cycle(); halt_req = 0; cycle();

    // breakpoint at 3
    fill_rom_plain();
    set_pc(4'd0);
    speed_sel = 2'b10; bp_en = 1; bp_addr = 4'd3;
    run_req = 1; cycle(); run_req = 0;
    base = ce_seen;
    for (int i = 0; i < 60 && state !== 2'b11; i++) cycle();
    chk("bp_state", state, 3);
    chk("bp_cause", halt_cause, 1);
    chk("bp_pc", pc, 3);
    repeat (2) cycle();
    chk("bp_ce_count", ce_seen - base, 3);
    run_req = 1; cycle(); run_req = 0;
    repeat (5) cycle();
    chk("bp_skip_pc", pc, 4);
    chk("bp_skip_state", state, 1);
    for (int i = 0; i < 100 && state !== 2'b11; i++) cycle();
    chk("bp_again_state", state, 3);
    chk("bp_again_pc", pc, 3);

    // halt from BRK keeps cause, then self-loop auto-halt
    halt_req = 1; cycle(); halt_req = 0;
    chk("brk_halt_state", state, 0);
    chk("brk_halt_cause", halt_cause, 1);
    bp_en = 0;
    rom[5] = 8'hF5;
    set_pc(4'd5);
    run_req = 1; cycle(); run_req = 0;
    base = ce_seen;
    for (int i = 0; i < 20 && state === 2'b01; i++) cycle();
    chk("loop_state", state, 0);
    chk("loop_cause", halt_cause, 2);
    cycle();
    chk("loop_ce_count", ce_seen - base, 1);
    chk("loop_pc", pc, 5);

    // single step
    fill_rom_plain();
    set_pc(4'd2);
    ic_before = m_icount;
    step_req = 1; cycle(); step_req = 0;
    cycle();
    chk("step_ce", cpu_ce, 1);
    chk("step_state", state, 0);
    chk("step_cause", halt_cause, 0);
    chk("step_icount", icount, ic_before + 1);
    cycle();
    chk("step_ce_off", cpu_ce, 0);

    // all requests together in HALT
    base = ce_seen;
    run_req = 1; halt_req = 1; step_req = 1;
    cycle();
    run_req = 0; halt_req = 0; step_req = 0;
    repeat (3) cycle();
    chk("prio_state", state, 0);
    chk("prio_ce", ce_seen - base, 0);

    // asynchronous reset while running
    speed_sel = 2'b11;
    run_req = 1; cycle(); run_req = 0;
    repeat (3) cycle();
    chk("pre_rst_ce", cpu_ce, 1);
    rst = 1'b1;
    #2;
    chk("async_ce", cpu_ce, 0);
    chk("async_state", state, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_pc(4'd0);

    // random requests against the model
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    memdata = rom[pc];
    repeat (1500) begin
      run_req  = ($urandom_range(0, 7) == 0);
      halt_req = ($urandom_range(0, 29) == 0);
      step_req = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) speed_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        bp_en = 1'($urandom);
        bp_addr = 4'($urandom);
      end
      cycle();
    end

    // saturation of icount
    run_req = 0; step_req = 0; bp_en = 0;
    fill_rom_plain();
    halt_req = 1; cycle(); halt_req = 0; cycle();
    speed_sel = 2'b11;
    run_req = 1; cycle(); run_req = 0;
    repeat (80) cycle();
    chk("sat_icount", icount, IC_MAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
